fp_addsub_arbiter: RTL
======================

FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 Parameter WI, default 4: integer bits of both signed fixed-point operands.
REQ-002 Parameter WF, default 4: fraction bits of both operands and of the result.
REQ-003 Parameter WIO, default 4: result integer bits; WIO >= WI.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-007 req_ready  out  2  per-requester grant/accept; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-008 req_op  in  2  per-requester operation: 0 = A+B, 1 = A-B.
REQ-009 req_a, req_b  in  2x(WI+WF) each  per-requester signed operands, packed with requester i at bits [i*(WI+WF) +: WI+WF].
REQ-010 rsp_valid  out  1  result valid.
REQ-011 rsp_ready  in  1  downstream accepts the result.
REQ-012 rsp_id  out  1  index of the requester that owns the result.
REQ-013 rsp_data  out  WIO+WF  signed result.
REQ-014 rsp_ovf  out  1  result exceeded the WIO+WF range.

Function
REQ-015 Block SHALL time-share one combinational add/sub unit between two requesters, with at most one transaction in flight.
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
- IDLE -> EXEC on a handshake.
- EXEC -> RESP unconditionally.
- RESP -> IDLE when rsp_ready is 1.
REQ-017 req_ready SHALL be nonzero only in IDLE, and SHALL be one-hot toward the winning valid requester; it is combinational from req_valid and the priority pointer.
REQ-018 Arbitration SHALL be round-robin. The pointer names the preferred requester, resets to 0, and on every accept moves to the requester that was not granted.
REQ-019 On accept, a, b, op and id SHALL be registered. In EXEC, the result and overflow SHALL be computed from the registered operands and registered into the response.
REQ-020 Latency: accept at cycle N gives rsp_valid = 1 at cycle N+2; throughput is at most one operation per 3 cycles.
REQ-021 Arithmetic SHALL be exact before range check.
- Sign-extend both operands to WI+WF+1 bits.
- Subtraction is A + (~B + 1) at that width, so B = most-negative is correct.
REQ-022 rsp_ovf SHALL be 1 when the exact result is outside [-2^(WIO+WF-1), 2^(WIO+WF-1)-1] in LSB units.
REQ-023 Without saturation, rsp_data SHALL be the low WIO+WF bits of the exact result (wrap).
REQ-024 rsp_valid, rsp_id, rsp_data and rsp_ovf SHALL be held stable in RESP until the cycle rsp_ready is 1, and rsp_valid SHALL drop the next cycle.
REQ-025 A requester dropping req_valid without a handshake SHALL have no effect; requests arriving in EXEC or RESP SHALL wait.
REQ-026 When both requesters are valid in IDLE, exactly one SHALL be granted: the pointer's requester.

Reset
REQ-027 While rst_n = 0, the following SHALL be forced:
- state = IDLE, pointer = 0;
- rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_ovf = 0;
- req_ready = 0;
- operand registers = 0.
REQ-028 Reset asserted mid-transaction SHALL discard it with no response. After release, the first response comes only from a new handshake.

Configuration
REQ-029 With macro FP_ADDSUB_SAT_EN defined, an overflowed rsp_data SHALL saturate to the positive or negative full-scale value by the sign of the exact result; rsp_ovf is unchanged.
REQ-030 Without FP_ADDSUB_SAT_EN, rsp_data SHALL wrap per REQ-023.

Structure
REQ-031 Package fp_arith_pkg SHALL hold:
- the op encoding constants OP_ADD = 0 and OP_SUB = 1;
- the FSM state typedef.
REQ-032 Add/subtract and range check SHALL live in combinational sub-module fp_addsub_unit, with parameters WI, WF, WIO and ports a, b, op, sum, ovf; the arbiter instantiates it once.

Verification (WI=4, WF=4, WIO=4; hex values are 8-bit)
REQ-033 Single requester: req0 add 0x18 (1.5) + 0x28 (2.5), rsp_ready = 1 -> rsp_valid 2 cycles after accept, data 0x40, ovf 0, id 0.
REQ-034 Both requesters valid continuously from reset -> grants alternate 0,1,0,1; each response id matches its grant.
REQ-035 Subtract 0x80 - 0x80 -> data 0x00, ovf 0. Subtract 0x00 - 0x80 -> ovf 1; data 0x80 without the macro, 0x7F with FP_ADDSUB_SAT_EN.
REQ-036 Add 0x70 + 0x70 -> ovf 1; data 0xE0 without the macro, 0x7F with it.
REQ-037 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable throughout, req_ready = 0; after rsp_ready = 1, the next request is accepted one cycle later.
REQ-038 rst_n pulsed low during EXEC -> outputs are at reset values immediately, no response for the aborted operation, and the pointer is back at 0.

Source files
------------

// File: rtl/fp_arith_pkg.sv
// Shared definitions for the fixed-point add/sub arbiter.
// Contents: op encodings, FSM state type, requester count.
package fp_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/fp_addsub_unit.sv
// Combinational signed fixed-point add/sub with exact range check.
// Ports:
//   a, b : signed operands, WI integer + WF fraction bits
//   op   : OP_ADD (a+b) or OP_SUB (a-b)
//   sum  : signed result, WIO integer + WF fraction bits
//   ovf  : exact result does not fit in the result width
// Macro FP_ADDSUB_SAT_EN: saturate sum on overflow instead of wrapping.
module fp_addsub_unit
  import fp_arith_pkg::*;
#(
  parameter int unsigned WI  = 4,
  parameter int unsigned WF  = 4,
  parameter int unsigned WIO = 4
) (
  input  logic [WI+WF-1:0]  a,
  input  logic [WI+WF-1:0]  b,
  input  logic              op,
  output logic [WIO+WF-1:0] sum,
  output logic              ovf
);

  localparam int unsigned WIN = WI + WF;
  localparam int unsigned WE  = WIN + 1;
  localparam int unsigned WO  = WIO + WF;
  localparam int unsigned WX  = (WE > WO) ? WE : WO;
  localparam int unsigned WT  = WX - WO + 1;

  logic [WE-1:0] a_ext;
  logic [WE-1:0] b_ext;
  logic [WE-1:0] b_term;
  logic [WE-1:0] exact;
  logic [WX-1:0] exact_x;
  logic [WT-1:0] top;
  logic [WO-1:0] wrap;

  // One guard bit makes both add and subtract exact, including b = most-negative.
  assign a_ext  = {a[WIN-1], a};
  assign b_ext  = {b[WIN-1], b};
  assign b_term = (op == OP_SUB) ? (~b_ext + WE'(1)) : b_ext;
  assign exact  = a_ext + b_term;

  assign exact_x = WX'($signed(exact));

  // Fits iff every bit from the result sign bit upward is a copy of the sign.
  assign top  = exact_x[WX-1:WO-1];
  assign ovf  = ~((&top) | (~|top));
  assign wrap = exact_x[WO-1:0];

`ifdef FP_ADDSUB_SAT_EN
  always_comb begin
    sum = wrap;
    if (ovf) begin
      sum = exact_x[WX-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    end
  end
`else
  assign sum = wrap;
`endif

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Two-requester round-robin front end sharing one fixed-point add/sub unit.
// One transaction in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : per-requester handshake (req_ready combinational)
//   req_op, req_a/req_b : per-requester op and packed signed operands
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_data, rsp_ovf : owner, result, overflow flag
// Macro FP_ADDSUB_SAT_EN: saturating result (see fp_addsub_unit).
module fp_addsub_arbiter
  import fp_arith_pkg::*;
#(
  parameter int unsigned WI  = 4,
  parameter int unsigned WF  = 4,
  parameter int unsigned WIO = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*(WI+WF)-1:0] req_a,
  input  logic [NUM_REQ*(WI+WF)-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [WIO+WF-1:0]          rsp_data,
  output logic                       rsp_ovf
);

  localparam int unsigned W  = WI + WF;
  localparam int unsigned WO = WIO + WF;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          op_q, op_d;
  logic          id_q, id_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [WO-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_ovf_q, rsp_ovf_d;

  logic               gnt_id;
  logic [NUM_REQ-1:0] grant;
  logic [WO-1:0]      unit_sum;
  logic               unit_ovf;

  fp_addsub_unit #(
    .WI (WI),
    .WF (WF),
    .WIO(WIO)
  ) u_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .sum(unit_sum),
    .ovf(unit_ovf)
  );

  // Next-state, arbitration and response capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    grant       = '0;
    gnt_id      = ptr_q;

    case (state_q)
      IDLE: begin
        // Preferred requester wins if valid, otherwise the other one.
        gnt_id = req_valid[ptr_q] ? ptr_q : ~ptr_q;
        if (req_valid[gnt_id]) begin
          grant[gnt_id] = 1'b1;
          a_d     = gnt_id ? req_a[2*W-1:W] : req_a[W-1:0];
          b_d     = gnt_id ? req_b[2*W-1:W] : req_b[W-1:0];
          op_d    = req_op[gnt_id];
          id_d    = gnt_id;
          ptr_d   = ~gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = unit_sum;
        rsp_ovf_d   = unit_ovf;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant must read as zero while reset is held, even though state is IDLE.
  assign req_ready = grant & {NUM_REQ{rst_n}};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule
